// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: DVI control tokens, ctrl-to-token mapping and decoder FSM states.
// Used by both the TMDS encoder and the channel decoder.
package tmds_pkg;

  localparam logic [9:0] TOK_CTRL0 = 10'b1101010100;
  localparam logic [9:0] TOK_CTRL1 = 10'b0010101011;
  localparam logic [9:0] TOK_CTRL2 = 10'b0101010100;
  localparam logic [9:0] TOK_CTRL3 = 10'b1010101011;

  localparam logic [3:0] OFFSET_MAX = 4'd9;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } dec_state_e;

  function automatic logic [9:0] ctrl_to_token(input logic [1:0] c);
    logic [9:0] tok;
    case (c)
      2'b00:   tok = TOK_CTRL0;
      2'b01:   tok = TOK_CTRL1;
      2'b10:   tok = TOK_CTRL2;
      default: tok = TOK_CTRL3;
    endcase
    return tok;
  endfunction

endpackage

// File: rtl/tmds_channel_decoder_if.sv
// Bus between the deserializer/pixel recovery logic and one TMDS channel decoder.
// lock_loss_cnt exists only when TMDS_DEC_LOCK_STATS_EN is defined.
interface tmds_channel_decoder_if;
  logic [9:0] raw_word;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic       de;
  logic       locked;
  logic [3:0] bit_offset;
`ifdef TMDS_DEC_LOCK_STATS_EN
  logic [15:0] lock_loss_cnt;

  modport master (output raw_word, input data, ctrl, de, locked, bit_offset, lock_loss_cnt);
  modport slave  (input raw_word, output data, ctrl, de, locked, bit_offset, lock_loss_cnt);
`else
  modport master (output raw_word, input data, ctrl, de, locked, bit_offset);
  modport slave  (input raw_word, output data, ctrl, de, locked, bit_offset);
`endif
endinterface

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol decoder: control-token match plus transition-minimised data decode.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [9:0] sym_i,
  output logic       is_token_o,
  output logic [1:0] ctrl_o,
  output logic [7:0] data_o
);

  logic [7:0] d;

  always_comb begin
    is_token_o = 1'b0;
    ctrl_o     = 2'b00;
    for (int c = 0; c < 4; c++) begin
      if (sym_i == ctrl_to_token(2'(c))) begin
        is_token_o = 1'b1;
        ctrl_o     = 2'(c);
      end
    end
  end

  // sym[9] undoes the DC-balance inversion, sym[8] selects XOR vs XNOR chaining
  always_comb begin
    d         = sym_i[9] ? ~sym_i[7:0] : sym_i[7:0];
    data_o    = 8'h00;
    data_o[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      data_o[i] = sym_i[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    if (is_token_o) data_o = 8'h00;
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
// TMDS channel receiver: bit alignment by control-token hunting, then 2-cycle symbol decode.
// Optional feature macro: TMDS_DEC_LOCK_STATS_EN adds a saturating lock-loss counter.
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN_MIN   = 4,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int LOCK_TIMEOUT   = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  tmds_channel_decoder_if.slave dec_if
);

  localparam int RUN_W  = $clog2(CTRL_RUN_MIN + 1);
  localparam int IDLE_W = ($clog2(LOCK_TIMEOUT) > $clog2(SEARCH_TIMEOUT)) ?
                          $clog2(LOCK_TIMEOUT) : $clog2(SEARCH_TIMEOUT);

  logic [9:0]        prev_word_q;
  logic [9:0]        sym_p1_q;
  logic [19:0]       win;
  logic              is_tok;
  logic [1:0]        tok_ctrl;
  logic [7:0]        dec_data;

  dec_state_e        state_q, state_d;
  logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [3:0]        offset_q, offset_d, offset_nxt;
  logic              locked_d;

  logic [7:0]        data_p2_q;
  logic [1:0]        ctrl_p2_q;
  logic              de_p2_q;

  // Stage p1: align the newest word against the previous one
  assign win = {dec_if.raw_word, prev_word_q};

  tmds_symbol_decode u_sym_dec (
    .sym_i      (sym_p1_q),
    .is_token_o (is_tok),
    .ctrl_o     (tok_ctrl),
    .data_o     (dec_data)
  );

  assign offset_nxt = (offset_q == OFFSET_MAX) ? 4'd0 : offset_q + 4'd1;

  // A token always wins over a coincident timeout
  always_comb begin
    state_d    = state_q;
    run_cnt_d  = run_cnt_q;
    idle_cnt_d = idle_cnt_q;
    offset_d   = offset_q;
    case (state_q)
      ST_SEARCH: begin
        if (is_tok) begin
          idle_cnt_d = '0;
          if (run_cnt_q == RUN_W'(CTRL_RUN_MIN - 1)) begin
            state_d   = ST_LOCKED;
            run_cnt_d = '0;
          end else begin
            run_cnt_d = run_cnt_q + 1'b1;
          end
        end else begin
          run_cnt_d = '0;
          if (idle_cnt_q == IDLE_W'(SEARCH_TIMEOUT - 1)) begin
            idle_cnt_d = '0;
            offset_d   = offset_nxt;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        if (is_tok) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_W'(LOCK_TIMEOUT - 1)) begin
          state_d    = ST_SEARCH;
          idle_cnt_d = '0;
          run_cnt_d  = '0;
          offset_d   = offset_nxt;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
    endcase
  end

  assign locked_d = (state_d == ST_LOCKED);

  // Stage p2: registered decode outputs, gated by the lock state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_word_q <= '0;
      sym_p1_q    <= '0;
      state_q     <= ST_SEARCH;
      run_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      offset_q    <= '0;
      data_p2_q   <= '0;
      ctrl_p2_q   <= '0;
      de_p2_q     <= 1'b0;
    end else begin
      prev_word_q <= dec_if.raw_word;
      sym_p1_q    <= win[offset_q +: 10];
      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      offset_q    <= offset_d;
      data_p2_q   <= dec_data;
      de_p2_q     <= locked_d & ~is_tok;
      if (!locked_d)   ctrl_p2_q <= 2'b00;
      else if (is_tok) ctrl_p2_q <= tok_ctrl;
    end
  end

  assign dec_if.data       = data_p2_q;
  assign dec_if.ctrl       = ctrl_p2_q;
  assign dec_if.de         = de_p2_q;
  assign dec_if.locked     = (state_q == ST_LOCKED);
  assign dec_if.bit_offset = offset_q;

`ifdef TMDS_DEC_LOCK_STATS_EN
  logic [15:0] lock_loss_q;
  logic        lock_lost;

  assign lock_lost = (state_q == ST_LOCKED) && (state_d == ST_SEARCH);

  always_ff @(posedge clk) begin
    if (rst)                                    lock_loss_q <= '0;
    else if (lock_lost && lock_loss_q != 16'hFFFF) lock_loss_q <= lock_loss_q + 16'd1;
  end

  assign dec_if.lock_loss_cnt = lock_loss_q;
`endif

endmodule
